// File: rtl/reg_file_pkg.sv
// reg_file_pkg
//   Shared constants, types and the write-port priority helper for the
//   multi-port register file.
//   Contents:
//     REG_DATA_WIDTH / REG_NUM / REG_PC_INDEX : default geometry (ARM core)
//     reg_addr_t   : 4-bit architectural register index
//     REG_MAX_WR   : widest write-port vector the priority helper accepts
//     wr_sel_t     : result of a priority match (hit flag + winning port)
//     wr_prio_sel  : highest-index enabled port among the matching ones
package reg_file_pkg;

    localparam int REG_DATA_WIDTH = 32;
    localparam int REG_NUM        = 16;
    localparam int REG_PC_INDEX   = 15;

    // Upper bound on NUM_WR supported by wr_prio_sel.
    localparam int REG_MAX_WR     = 8;

    typedef logic [3:0] reg_addr_t;

    typedef struct packed {
        logic       hit;
        logic [2:0] port;
    } wr_sel_t;

    // Ascending scan so the last (highest-index) matching port wins.
    function automatic wr_sel_t wr_prio_sel(input logic [REG_MAX_WR-1:0] hit_vec);
        wr_sel_t sel;
        sel.hit  = 1'b0;
        sel.port = 3'd0;
        for (int i = 0; i < REG_MAX_WR; i++) begin
            if (hit_vec[i]) begin
                sel.hit  = 1'b1;
                sel.port = 3'(i);
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/reg_file_mp_if.sv
// reg_file_mp_if
//   Bundle of the register-file bus between decode/writeback (master) and
//   the register file (slave).
//   Signals:
//     wr_en/wr_addr/wr_data       : NUM_WR packed write ports
//     rd_addr/rd_data             : NUM_RD packed read ports (data combinational)
//     pc_value                    : value returned for the PC index
//     busy_set_en/busy_set_addr   : mark a destination as pending
//     busy/rd_busy                : scoreboard vector and per-read hazard flags
//     write_conflict              : registered same-address multi-write pulse
interface reg_file_mp_if #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 16,
    parameter int NUM_RD     = 3,
    parameter int NUM_WR     = 2
);
    localparam int AW = $clog2(NUM_REGS);

    logic [NUM_WR-1:0]            wr_en;
    logic [NUM_WR*AW-1:0]         wr_addr;
    logic [NUM_WR*DATA_WIDTH-1:0] wr_data;
    logic [NUM_RD*AW-1:0]         rd_addr;
    logic [NUM_RD*DATA_WIDTH-1:0] rd_data;
    logic [DATA_WIDTH-1:0]        pc_value;
    logic                         busy_set_en;
    logic [AW-1:0]                busy_set_addr;
    logic [NUM_REGS-1:0]          busy;
    logic [NUM_RD-1:0]            rd_busy;
    logic                         write_conflict;

    modport master (
        output wr_en, wr_addr, wr_data, rd_addr, pc_value, busy_set_en, busy_set_addr,
        input  rd_data, busy, rd_busy, write_conflict
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rd_addr, pc_value, busy_set_en, busy_set_addr,
        output rd_data, busy, rd_busy, write_conflict
    );

endinterface

// File: rtl/reg_scoreboard.sv
// reg_scoreboard
//   Pending-write scoreboard: one busy bit per architectural register.
//   A busy_set marks a register pending; any write to it clears the bit.
//   Set beats clear in the same cycle (a newer producer has been issued).
//   Ports:
//     clk, reset            : clock, synchronous active-high reset
//     wr_en, wr_addr        : write ports (clear sources)
//     busy_set_en/_addr     : set source from decode
//     busy                  : registered busy vector
import reg_file_pkg::*;

module reg_scoreboard #(
    parameter int NUM_REGS = REG_NUM,
    parameter int NUM_WR   = 2,
    parameter int PC_INDEX = REG_PC_INDEX
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [NUM_WR-1:0]                   wr_en,
    input  logic [NUM_WR*$clog2(NUM_REGS)-1:0]  wr_addr,
    input  logic                                busy_set_en,
    input  logic [$clog2(NUM_REGS)-1:0]         busy_set_addr,
    output logic [NUM_REGS-1:0]                 busy
);
    localparam int AW = $clog2(NUM_REGS);

    logic [NUM_REGS-1:0] busy_r;
    logic [NUM_REGS-1:0] busy_next_s;
    logic [NUM_REGS-1:0] clear_s;

    // Per-register next state: set > clear > hold; PC bit pinned to 0.
    always_comb begin
        clear_s     = '0;
        busy_next_s = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            for (int i = 0; i < NUM_WR; i++) begin
                clear_s[r] = clear_s[r] | (wr_en[i] && (wr_addr[i*AW +: AW] == AW'(r)));
            end
            if (r == PC_INDEX) begin
                busy_next_s[r] = 1'b0;
            end else if (busy_set_en && (busy_set_addr == AW'(r))) begin
                busy_next_s[r] = 1'b1;
            end else if (clear_s[r]) begin
                busy_next_s[r] = 1'b0;
            end else begin
                busy_next_s[r] = busy_r[r];
            end
        end
    end

    // Busy vector register.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_r <= '0;
        end else begin
            busy_r <= busy_next_s;
        end
    end

    assign busy = busy_r;

endmodule

// File: rtl/reg_file_mp.sv
// reg_file_mp
//   Parametrised multi-port register file with fixed-priority writes
//   (highest port index wins), optional same-cycle write-to-read bypass,
//   a pending-write scoreboard and a registered write-conflict flag.
//   The PC_INDEX entry is never written; reads of it return pc_value.
//   Ports:
//     clk, reset : clock, synchronous active-high reset
//     bus        : reg_file_mp_if slave modport (write/read ports, pc_value,
//                  busy set, busy, rd_busy, write_conflict)
import reg_file_pkg::*;

module reg_file_mp #(
    parameter int DATA_WIDTH = REG_DATA_WIDTH,
    parameter int NUM_REGS   = REG_NUM,
    parameter int NUM_RD     = 3,
    parameter int NUM_WR     = 2,
    parameter int PC_INDEX   = REG_PC_INDEX,
    parameter int BYPASS     = 1
) (
    input  logic          clk,
    input  logic          reset,
    reg_file_mp_if.slave  bus
);
    localparam int            AW      = $clog2(NUM_REGS);
    localparam logic [AW-1:0] PC_ADDR = AW'(PC_INDEX);

    logic [DATA_WIDTH-1:0] mem_r      [NUM_REGS];
    wr_sel_t               reg_sel_s  [NUM_REGS];
    wr_sel_t               rd_sel_s   [NUM_RD];
    logic [AW-1:0]         rd_addr_s  [NUM_RD];
    logic                  rd_valid_s [NUM_RD];
    logic [NUM_REGS-1:0]   busy_s;
    logic                  conflict_s;
    logic                  conflict_r;

    // Which enabled write ports target addr (bit i = port i).
    function automatic logic [REG_MAX_WR-1:0] port_hits(
        input logic [NUM_WR-1:0]    en,
        input logic [NUM_WR*AW-1:0] addrs,
        input logic [AW-1:0]        addr
    );
        logic [REG_MAX_WR-1:0] h;
        h = '0;
        for (int i = 0; i < NUM_WR; i++) begin
            h[i] = en[i] && (addrs[i*AW +: AW] == addr);
        end
        return h;
    endfunction

    // Winning write port for every storage entry.
    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            reg_sel_s[r] = wr_prio_sel(port_hits(bus.wr_en, bus.wr_addr, AW'(r)));
        end
    end

    // Storage update; the PC entry keeps its reset value forever.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                mem_r[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if ((r != PC_INDEX) && reg_sel_s[r].hit) begin
                    mem_r[r] <= bus.wr_data[int'(reg_sel_s[r].port)*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    // Any pair of enabled ports sharing a non-PC address.
    always_comb begin
        conflict_s = 1'b0;
        for (int i = 0; i < NUM_WR; i++) begin
            for (int j = i + 1; j < NUM_WR; j++) begin
                conflict_s = conflict_s |
                    (bus.wr_en[i] && bus.wr_en[j] &&
                     (bus.wr_addr[i*AW +: AW] == bus.wr_addr[j*AW +: AW]) &&
                     (bus.wr_addr[i*AW +: AW] != PC_ADDR));
            end
        end
    end

    // Conflict flag is a one-cycle registered pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            conflict_r <= 1'b0;
        end else begin
            conflict_r <= conflict_s;
        end
    end

    // Read mux and hazard flags per read port.
    always_comb begin
        bus.rd_data = '0;
        bus.rd_busy = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            rd_addr_s[k]  = bus.rd_addr[k*AW +: AW];
            rd_sel_s[k]   = wr_prio_sel(port_hits(bus.wr_en, bus.wr_addr, rd_addr_s[k]));
            // In range and not the PC: a real storage entry.
            rd_valid_s[k] = (int'(rd_addr_s[k]) < NUM_REGS) && (rd_addr_s[k] != PC_ADDR);
            if (rd_addr_s[k] == PC_ADDR) begin
                bus.rd_data[k*DATA_WIDTH +: DATA_WIDTH] = bus.pc_value;
            end else if (!rd_valid_s[k]) begin
                bus.rd_data[k*DATA_WIDTH +: DATA_WIDTH] = '0;
            end else if ((BYPASS != 0) && rd_sel_s[k].hit) begin
                bus.rd_data[k*DATA_WIDTH +: DATA_WIDTH] =
                    bus.wr_data[int'(rd_sel_s[k].port)*DATA_WIDTH +: DATA_WIDTH];
            end else begin
                bus.rd_data[k*DATA_WIDTH +: DATA_WIDTH] = mem_r[rd_addr_s[k]];
            end
            // A bypassed value is already the produced result, so no hazard.
            if (rd_valid_s[k]) begin
                bus.rd_busy[k] = busy_s[rd_addr_s[k]] && !((BYPASS != 0) && rd_sel_s[k].hit);
            end else begin
                bus.rd_busy[k] = 1'b0;
            end
        end
    end

    reg_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .NUM_WR   (NUM_WR),
        .PC_INDEX (PC_INDEX)
    ) u_scoreboard (
        .clk           (clk),
        .reset         (reset),
        .wr_en         (bus.wr_en),
        .wr_addr       (bus.wr_addr),
        .busy_set_en   (bus.busy_set_en),
        .busy_set_addr (bus.busy_set_addr),
        .busy          (busy_s)
    );

    assign bus.busy           = busy_s;
    assign bus.write_conflict = conflict_r;

endmodule

// File: tb/tb_reg_file_mp.sv
// tb_reg_file_mp
//   Directed bench for reg_file_mp. Three instances:
//     dut_m  : default geometry, BYPASS=1
//     dut_nb : default geometry, BYPASS=0, inputs mirrored from dut_m's bus
//     dut_p  : 16-bit, 8 regs, 4 read, 3 write ports, PC_INDEX=7
module tb_reg_file_mp;
    import reg_file_pkg::*;

    logic clk;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;

    reg_file_mp_if #(.DATA_WIDTH(32), .NUM_REGS(16), .NUM_RD(3), .NUM_WR(2)) m_if ();
    reg_file_mp_if #(.DATA_WIDTH(32), .NUM_REGS(16), .NUM_RD(3), .NUM_WR(2)) nb_if ();
    reg_file_mp_if #(.DATA_WIDTH(16), .NUM_REGS(8),  .NUM_RD(4), .NUM_WR(3)) p_if ();

    reg_file_mp #(.DATA_WIDTH(32), .NUM_REGS(16), .NUM_RD(3), .NUM_WR(2),
                  .PC_INDEX(15), .BYPASS(1)) dut_m (.clk(clk), .reset(reset), .bus(m_if));
    reg_file_mp #(.DATA_WIDTH(32), .NUM_REGS(16), .NUM_RD(3), .NUM_WR(2),
                  .PC_INDEX(15), .BYPASS(0)) dut_nb (.clk(clk), .reset(reset), .bus(nb_if));
    reg_file_mp #(.DATA_WIDTH(16), .NUM_REGS(8), .NUM_RD(4), .NUM_WR(3),
                  .PC_INDEX(7), .BYPASS(1)) dut_p (.clk(clk), .reset(reset), .bus(p_if));

    assign nb_if.wr_en         = m_if.wr_en;
    assign nb_if.wr_addr       = m_if.wr_addr;
    assign nb_if.wr_data       = m_if.wr_data;
    assign nb_if.rd_addr       = m_if.rd_addr;
    assign nb_if.pc_value      = m_if.pc_value;
    assign nb_if.busy_set_en   = m_if.busy_set_en;
    assign nb_if.busy_set_addr = m_if.busy_set_addr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_rd(input int k, input reg_addr_t a);
        m_if.rd_addr[k*4 +: 4] = a;
    endtask

    task automatic set_wr(input int i, input reg_addr_t a, input logic [31:0] d);
        m_if.wr_addr[i*4 +: 4]   = a;
        m_if.wr_data[i*32 +: 32] = d;
    endtask

    function automatic logic [31:0] rd_m(input int k);
        return m_if.rd_data[k*32 +: 32];
    endfunction

    function automatic logic [31:0] rd_nb(input int k);
        return nb_if.rd_data[k*32 +: 32];
    endfunction

    task automatic p_set_wr(input int i, input logic [2:0] a, input logic [15:0] d);
        p_if.wr_addr[i*3 +: 3]   = a;
        p_if.wr_data[i*16 +: 16] = d;
    endtask

    function automatic logic [31:0] rd_p(input int k);
        return 32'(p_if.rd_data[k*16 +: 16]);
    endfunction

    initial begin
        logic [31:0] p_exp [4];
        logic [2:0]  p_addr [4];

        reset              = 1'b1;
        m_if.wr_en         = 2'b00;
        m_if.wr_addr       = '0;
        m_if.wr_data       = '0;
        m_if.rd_addr       = '0;
        m_if.pc_value      = 32'h0000_0108;
        m_if.busy_set_en   = 1'b0;
        m_if.busy_set_addr = 4'd0;
        p_if.wr_en         = 3'b000;
        p_if.wr_addr       = '0;
        p_if.wr_data       = '0;
        p_if.rd_addr       = '0;
        p_if.pc_value      = 16'hBEEF;
        p_if.busy_set_en   = 1'b0;
        p_if.busy_set_addr = 3'd0;
        tick();
        tick();
        reset = 1'b0;
        settle();

        // Reset state
        check_eq("rst_busy", 32'(m_if.busy), 32'h0);
        check_eq("rst_wc", 32'(m_if.write_conflict), 32'h0);
        for (int a = 0; a < 15; a++) begin
            set_rd(0, reg_addr_t'(a));
            settle();
            check_eq($sformatf("rst_r%0d", a), rd_m(0), 32'h0);
        end
        set_rd(0, 4'd15);
        settle();
        check_eq("rst_pc", rd_m(0), 32'h0000_0108);
        tick();

        // Single write, bypass vs. no bypass
        m_if.wr_en = 2'b01;
        set_wr(0, 4'd3, 32'hDEAD_BEEF);
        set_rd(0, 4'd3);
        settle();
        check_eq("byp_r3", rd_m(0), 32'hDEAD_BEEF);
        check_eq("nobyp_r3_old", rd_nb(0), 32'h0);
        tick();
        m_if.wr_en = 2'b00;
        settle();
        check_eq("wr_r3", rd_m(0), 32'hDEAD_BEEF);
        check_eq("wr_r3_nb", rd_nb(0), 32'hDEAD_BEEF);
        check_eq("wc_single", 32'(m_if.write_conflict), 32'h0);

        // Two-port collision on r5: port1 wins, conflict pulse
        m_if.wr_en = 2'b11;
        set_wr(0, 4'd5, 32'h0000_0011);
        set_wr(1, 4'd5, 32'h0000_0022);
        set_rd(1, 4'd5);
        settle();
        check_eq("byp_coll_r5", rd_m(1), 32'h0000_0022);
        tick();
        m_if.wr_en = 2'b00;
        settle();
        check_eq("coll_r5", rd_m(1), 32'h0000_0022);
        check_eq("coll_r5_nb", rd_nb(1), 32'h0000_0022);
        check_eq("wc_pulse", 32'(m_if.write_conflict), 32'h1);
        tick();
        check_eq("wc_drop", 32'(m_if.write_conflict), 32'h0);

        // Writes to PC ignored, never bypassed, no conflict on PC
        m_if.wr_en = 2'b11;
        set_wr(0, 4'd15, 32'h0000_0055);
        set_wr(1, 4'd15, 32'h0000_0066);
        set_rd(2, 4'd15);
        settle();
        check_eq("pc_nobyp", rd_m(2), 32'h0000_0108);
        tick();
        m_if.wr_en = 2'b00;
        settle();
        check_eq("pc_after_wr", rd_m(2), 32'h0000_0108);
        check_eq("wc_pc", 32'(m_if.write_conflict), 32'h0);
        m_if.pc_value = 32'h0000_0200;
        settle();
        check_eq("pc_follow", rd_m(2), 32'h0000_0200);

        // Scoreboard set / bypass mask / clear
        m_if.busy_set_en   = 1'b1;
        m_if.busy_set_addr = 4'd7;
        tick();
        m_if.busy_set_en = 1'b0;
        set_rd(0, 4'd7);
        settle();
        check_eq("busy_set7", 32'(m_if.busy), 32'h0000_0080);
        check_eq("rdbusy_r7", 32'(m_if.rd_busy[0]), 32'h1);
        check_eq("rdbusy_pc", 32'(m_if.rd_busy[2]), 32'h0);
        m_if.wr_en = 2'b10;
        set_wr(1, 4'd7, 32'h0000_0077);
        settle();
        check_eq("rdbusy_mask", 32'(m_if.rd_busy[0]), 32'h0);
        check_eq("rdbusy_nomask_nb", 32'(nb_if.rd_busy[0]), 32'h1);
        tick();
        m_if.wr_en = 2'b00;
        settle();
        check_eq("busy_clr7", 32'(m_if.busy), 32'h0);
        check_eq("wr_r7", rd_m(0), 32'h0000_0077);

        // Set and clear together: set wins; PC set ignored
        m_if.busy_set_en   = 1'b1;
        m_if.busy_set_addr = 4'd7;
        m_if.wr_en         = 2'b01;
        set_wr(0, 4'd7, 32'h0000_0078);
        tick();
        m_if.wr_en         = 2'b00;
        m_if.busy_set_addr = 4'd15;
        tick();
        m_if.busy_set_en = 1'b0;
        settle();
        check_eq("busy_set_wins", 32'(m_if.busy), 32'h0000_0080);

        // Reset dominates a concurrent write and busy set
        reset              = 1'b1;
        m_if.wr_en         = 2'b01;
        set_wr(0, 4'd2, 32'h0000_1234);
        m_if.busy_set_en   = 1'b1;
        m_if.busy_set_addr = 4'd2;
        tick();
        reset            = 1'b0;
        m_if.wr_en       = 2'b00;
        m_if.busy_set_en = 1'b0;
        set_rd(0, 4'd2);
        set_rd(1, 4'd5);
        settle();
        check_eq("rst_wr_lost", rd_m(0), 32'h0);
        check_eq("rst_r5", rd_m(1), 32'h0);
        check_eq("rst_busy2", 32'(m_if.busy), 32'h0);
        tick();

        // Parameter sweep instance
        p_if.wr_en = 3'b011;
        p_set_wr(0, 3'd2, 16'h2222);
        p_set_wr(1, 3'd3, 16'h3333);
        p_set_wr(2, 3'd0, 16'h0000);
        tick();
        settle();
        check_eq("p_wc_distinct", 32'(p_if.write_conflict), 32'h0);
        p_if.wr_en = 3'b111;
        p_set_wr(0, 3'd1, 16'h00A1);
        p_set_wr(1, 3'd1, 16'h00B2);
        p_set_wr(2, 3'd1, 16'h00C3);
        p_if.rd_addr[0 +: 3] = 3'd1;
        settle();
        check_eq("p_byp_r1", rd_p(0), 32'h0000_00C3);
        tick();
        p_if.wr_en = 3'b000;
        p_addr[0] = 3'd1; p_exp[0] = 32'h0000_00C3;
        p_addr[1] = 3'd2; p_exp[1] = 32'h0000_2222;
        p_addr[2] = 3'd3; p_exp[2] = 32'h0000_3333;
        p_addr[3] = 3'd7; p_exp[3] = 32'h0000_BEEF;
        for (int k = 0; k < 4; k++) begin
            p_if.rd_addr[k*3 +: 3] = p_addr[k];
        end
        settle();
        for (int k = 0; k < 4; k++) begin
            check_eq($sformatf("p_rd%0d", k), rd_p(k), p_exp[k]);
        end
        check_eq("p_wc_pulse", 32'(p_if.write_conflict), 32'h1);
        tick();
        check_eq("p_wc_drop", 32'(p_if.write_conflict), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
